io_uart_port: RTL

- Peripheral on the far end of the cpu15 I/O word interface.
- Consumes the CPU's 16-bit output word IO64_OUT as a command/transmit register and serialises transmit bytes onto TXD (8N1 UART).
- Deserialises RXD and presents received byte plus status on the 16-bit input word IO65_IN, which the CPU reads through its RAM address 65 path.
- Handshakes use toggle bits, so single CPU writes are never missed regardless of CPU stage timing.

---
 rtl/io_uart_port.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/io_uart_port.sv
// 8N1 UART peripheral behind the cpu15 I/O words: IO64_OUT carries commands/TX byte,
// IO65_IN returns TX handshake state and the received byte with its status flags.
module io_uart_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] IO64_OUT,
  output logic [15:0] IO65_IN,
  input  logic        RXD,
  output logic        TXD
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_txState;
  logic [CW-1:0] r_txCnt;
  logic [2:0]    r_txBitIdx;
  logic [7:0]    r_txShift;
  logic          r_txReqSeen;
  logic          r_txAck;
  logic          r_txBusy;
  logic          r_txd;

  state_t        r_rxState;
  logic [CW-1:0] r_rxCnt;
  logic [2:0]    r_rxBitIdx;
  logic [7:0]    r_rxShift;
  logic [7:0]    r_rxByte;
  logic          r_rxValid;
  logic          r_rxOverrun;
  logic          r_rxFrameErr;
  logic          r_rxAckSeen;
  logic [1:0]    r_rxSync;

  logic w_txReq;
  logic w_rxAck;
  logic w_rxd;
  logic w_unused;

  assign w_txReq  = IO64_OUT[15] != r_txReqSeen;
  assign w_rxAck  = IO64_OUT[14] != r_rxAckSeen;
  assign w_rxd    = r_rxSync[1];
  assign w_unused = ^IO64_OUT[13:8];

  assign TXD     = r_txd;
  assign IO65_IN = {r_txAck, r_txBusy, r_rxValid, r_rxOverrun, r_rxFrameErr, 3'b000, r_rxByte};

  always_ff @(posedge CLK) begin
    if (!RESET_N) r_rxSync <= 2'b11;
    else          r_rxSync <= {r_rxSync[0], RXD};
  end

  // A toggle pending at the end of STOP is accepted on that same edge so frames abut.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_txState   <= S_IDLE;
      r_txCnt     <= '0;
      r_txBitIdx  <= '0;
      r_txShift   <= '0;
      r_txReqSeen <= 1'b0;
      r_txAck     <= 1'b0;
      r_txBusy    <= 1'b0;
      r_txd       <= 1'b1;
    end else begin
      case (r_txState)
        S_IDLE: begin
          if (w_txReq) begin
            r_txShift   <= IO64_OUT[7:0];
            r_txReqSeen <= IO64_OUT[15];
            r_txAck     <= IO64_OUT[15];
            r_txBusy    <= 1'b1;
            r_txd       <= 1'b0;
            r_txCnt     <= '0;
            r_txState   <= S_START;
          end
        end
        S_START: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt    <= '0;
            r_txBitIdx <= '0;
            r_txd      <= r_txShift[0];
            r_txState  <= S_DATA;
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt <= '0;
            if (r_txBitIdx == 3'd7) begin
              r_txd     <= 1'b1;
              r_txState <= S_STOP;
            end else begin
              r_txBitIdx <= r_txBitIdx + 3'd1;
              r_txd      <= r_txShift[1];
              r_txShift  <= {1'b0, r_txShift[7:1]};
            end
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_txCnt == LAST_CNT) begin
            r_txCnt   <= '0;
            r_txBusy  <= 1'b0;
            r_txState <= S_IDLE;
            if (w_txReq) begin
              r_txShift   <= IO64_OUT[7:0];
              r_txReqSeen <= IO64_OUT[15];
              r_txAck     <= IO64_OUT[15];
              r_txBusy    <= 1'b1;
              r_txd       <= 1'b0;
              r_txState   <= S_START;
            end
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
        default: r_txState <= S_IDLE;
      endcase
    end
  end

  // The ack clear is written first so a same-cycle good stop sample can still load the new byte.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_rxState    <= S_IDLE;
      r_rxCnt      <= '0;
      r_rxBitIdx   <= '0;
      r_rxShift    <= '0;
      r_rxByte     <= '0;
      r_rxValid    <= 1'b0;
      r_rxOverrun  <= 1'b0;
      r_rxFrameErr <= 1'b0;
      r_rxAckSeen  <= 1'b0;
    end else begin
      if (w_rxAck) begin
        r_rxAckSeen  <= IO64_OUT[14];
        r_rxValid    <= 1'b0;
        r_rxOverrun  <= 1'b0;
        r_rxFrameErr <= 1'b0;
      end
      case (r_rxState)
        S_IDLE: begin
          if (!w_rxd) begin
            r_rxCnt   <= '0;
            r_rxState <= S_START;
          end
        end
        S_START: begin
          if (r_rxCnt == HALF_CNT) begin
            r_rxCnt    <= '0;
            r_rxBitIdx <= '0;
            r_rxState  <= w_rxd ? S_IDLE : S_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rxCnt == LAST_CNT) begin
            r_rxCnt   <= '0;
            r_rxShift <= {w_rxd, r_rxShift[7:1]};
            if (r_rxBitIdx == 3'd7) r_rxState <= S_STOP;
            else                    r_rxBitIdx <= r_rxBitIdx + 3'd1;
          end else begin
            r_rxCnt <= r_rxCnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_rxCnt == LAST_CNT) begin
            r_rxCnt   <= '0;
            r_rxState <= S_IDLE;
            if (w_rxd) begin
              if (w_rxAck || !r_rxValid) begin
                r_rxByte  <= r_rxShift;
                r_rxValid <= 1'b1;
              end else begin
                r_rxOverrun <= 1'b1;
              end
            end else begin
              r_rxFrameErr <= 1'b1;
            end
          end else begin
            r_rxCnt <= r_rxCnt + 1'b1;
          end
        end
        default: r_rxState <= S_IDLE;
      endcase
    end
  end

endmodule
